// File: rtl/rv32m_iterative_divider.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU unit: restoring radix-2, one quotient bit per cycle.
// start/busy/done handshake; WIDTH+2 cycles normally, 2 cycles for divide-by-zero/overflow.
module rv32m_iterative_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic [1:0]       DivOp,
  input  logic [WIDTH-1:0] Op1,
  input  logic [WIDTH-1:0] Op2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           r_state;
  state_t           w_next;
  logic [1:0]       r_op;
  logic             r_s1;
  logic             r_s2;
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [CNT_W-1:0] r_cnt;
  logic             r_special;
  logic [WIDTH-1:0] r_spec_res;
  logic [WIDTH-1:0] r_result;

  logic             w_accept;
  logic             w_signed;
  logic             w_s1;
  logic             w_s2;
  logic [WIDTH-1:0] w_abs1;
  logic [WIDTH-1:0] w_abs2;
  logic             w_div0;
  logic             w_ovf;
  logic             w_special;
  logic [WIDTH-1:0] w_spec_res;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic             w_ge;
  logic [WIDTH-1:0] w_fix_res;

  assign w_accept = start && !flush && (r_state == S_IDLE || r_state == S_DONE);
  assign w_signed = ~DivOp[0];
  assign w_s1     = w_signed & Op1[WIDTH-1];
  assign w_s2     = w_signed & Op2[WIDTH-1];
  assign w_abs1   = w_s1 ? -Op1 : Op1;
  assign w_abs2   = w_s2 ? -Op2 : Op2;
  assign w_div0   = (Op2 == '0);
  assign w_ovf    = w_signed && (Op1 == MIN_INT) && (Op2 == '1);
  assign w_special = w_div0 | w_ovf;

  always_comb begin
    w_spec_res = '0;
    if (w_div0)
      w_spec_res = DivOp[1] ? Op1 : '1;
    else
      w_spec_res = DivOp[1] ? '0 : MIN_INT;
  end

  // rem < divisor keeps the trial below 2^WIDTH when it succeeds, so its MSB alone flags a borrow.
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_trial = w_shift - {1'b0, r_divisor};
  assign w_ge    = ~w_trial[WIDTH];

  always_comb begin
    w_fix_res = r_quo;
    if (r_special)
      w_fix_res = r_spec_res;
    else begin
      case (r_op)
        2'b00:   w_fix_res = (r_s1 ^ r_s2) ? -r_quo : r_quo;
        2'b01:   w_fix_res = r_quo;
        2'b10:   w_fix_res = r_s1 ? -r_rem : r_rem;
        default: w_fix_res = r_rem;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (flush)
      w_next = S_IDLE;
    else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept)
            w_next = w_special ? S_FIX : S_CALC;
          else
            w_next = S_IDLE;
        end
        S_CALC:  w_next = (r_cnt == '0) ? S_FIX : S_CALC;
        S_FIX:   w_next = S_DONE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (r_state == S_CALC) || (r_state == S_FIX);
    done = (r_state == S_DONE);
  end

  assign Result = r_result;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op       <= '0;
      r_s1       <= 1'b0;
      r_s2       <= 1'b0;
      r_divisor  <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_cnt      <= '0;
      r_special  <= 1'b0;
      r_spec_res <= '0;
      r_result   <= '0;
    end else if (!flush) begin
      if (w_accept) begin
        r_op       <= DivOp;
        r_s1       <= w_s1;
        r_s2       <= w_s2;
        r_divisor  <= w_abs2;
        r_quo      <= w_abs1;
        r_rem      <= '0;
        r_cnt      <= CNT_W'(WIDTH-1);
        r_special  <= w_special;
        r_spec_res <= w_spec_res;
      end else if (r_state == S_CALC) begin
        r_rem <= w_ge ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
        r_quo <= {r_quo[WIDTH-2:0], w_ge};
        r_cnt <= r_cnt - CNT_W'(1);
      end else if (r_state == S_FIX) begin
        r_result <= w_fix_res;
      end
    end
  end

endmodule
